// File: rtl/vscale_fetch_unit_pkg.sv
// Shared types and constants for the vscale instruction fetch front end.
package vscale_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0200;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        badmem;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/vscale_fetch_unit_if.sv
// Instruction memory port and DX-facing handshake of the fetch unit.
interface vscale_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_badmem_e;

    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_badmem;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_inst, out_badmem,
        input  imem_wait, imem_rdata, imem_badmem_e, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_inst, out_badmem,
        output imem_wait, imem_rdata, imem_badmem_e, out_ready
    );

endinterface

// File: rtl/vscale_fetch_unit_queue.sv
// Circular FIFO of fetched {pc, inst, badmem} entries; flush wins over push and pop.
module vscale_fetch_queue
    import vscale_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [PTR_W-1:0] count_o,
    output logic             valid_o,
    output fetch_entry_t     head_o
);

    localparam int IDX_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     last_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & ((count_q != PTR_W'(DEPTH)) | do_pop);
    assign count_o = count_q;
    // Once empty the head keeps showing the last entry DX saw.
    assign head_o  = valid_o ? mem_q[rd_ptr_q[IDX_W-1:0]] : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (valid_o)
                last_q <= head_o;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push)
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + PTR_W'(do_push) - PTR_W'(do_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/vscale_fetch_unit.sv
// Fetch front end: sequential PC generation, single-outstanding imem requests,
// credit-limited buffering toward DX, halt on fetch fault, redirect/flush.
module vscale_fetch_unit
    import vscale_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    vscale_fetch_unit_if.master        bus
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;

    logic [PTR_W-1:0] count;
    logic             credit_ok, req, accept, push, pop, q_valid;
    fetch_entry_t     resp_entry, head;

    // A slot is reserved for every request in flight, so a response never overflows.
    assign credit_ok  = (32'(count) + 32'(inflight_q)) < 32'(DEPTH);
    assign req        = ~reset & (state_q == RUN) & ~redirect & credit_ok;
    assign accept     = req & ~bus.imem_wait;
    assign push       = inflight_q & ~drop_q & ~redirect;
    assign pop        = q_valid & bus.out_ready;
    assign resp_entry = '{pc: req_pc_q, inst: bus.imem_rdata, badmem: bus.imem_badmem_e};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        drop_d     = 1'b0;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            state_d    = RUN;
            drop_d     = 1'b1;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end
            if (push && bus.imem_badmem_e)
                state_d = HALTED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    vscale_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (resp_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (count),
        .valid_o     (q_valid),
        .head_o      (head)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.out_valid  = q_valid;
    assign bus.out_pc     = head.pc;
    assign bus.out_inst   = head.inst;
    assign bus.out_badmem = head.badmem;

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Scoreboard bench for vscale_fetch_unit: memory returns the address as data.
module tb_vscale_fetch_unit;
    import vscale_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    vscale_fetch_unit_if bus();

    vscale_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0200)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    int           bad_seen = 0;
    fetch_entry_t sb[$];

    logic        wait_c = 1'b0, ready_c = 1'b1, redir_c = 1'b0;
    logic [31:0] rpc_c = '0, bad_addr = 32'h0000_0001;
    logic        resp_now = 1'b0, pend = 1'b0, halted = 1'b0;
    logic [31:0] resp_addr = '0, pend_addr = '0, exp_addr = 32'h0000_0200;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_phase();
        resp_now          = pend;
        resp_addr         = pend_addr;
        bus.imem_rdata    = pend ? pend_addr : 32'hDEAD_BEEF;
        bus.imem_badmem_e = pend && (pend_addr == bad_addr);
        bus.imem_wait     = wait_c;
        bus.out_ready     = ready_c;
        redirect          = redir_c;
        redirect_pc       = rpc_c;
    endtask

    task automatic sample_phase();
        logic         exp_req;
        logic         acc;
        fetch_entry_t e;
        exp_req = !halted && !redir_c && ((sb.size() + int'(resp_now)) < 4);
        check_val("imem_req", 32'(bus.imem_req), 32'(exp_req));
        check_val("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        acc = bus.imem_req && !wait_c;
        if (acc) begin
            check_val("imem_addr", bus.imem_addr, exp_addr);
            pend_addr = exp_addr;
            exp_addr  = exp_addr + 32'd4;
        end
        if (redir_c) begin
            sb.delete();
            exp_addr = rpc_c & 32'hFFFF_FFFC;
            halted   = 1'b0;
        end else begin
            if (bus.out_valid && ready_c && sb.size() != 0) begin
                e = sb.pop_front();
                check_val("out_pc", bus.out_pc, e.pc);
                check_val("out_inst", bus.out_inst, e.inst);
                check_val("out_badmem", 32'(bus.out_badmem), 32'(e.badmem));
                if (bus.out_badmem) bad_seen++;
            end
            if (resp_now) begin
                e.pc     = resp_addr;
                e.inst   = resp_addr;
                e.badmem = (resp_addr == bad_addr);
                sb.push_back(e);
                if (e.badmem) halted = 1'b1;
            end
        end
        pend = acc;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_phase();
        @(negedge clk);
        sample_phase();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        drive_phase();
        #1 reset = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_out_pc", bus.out_pc, 32'd0);
        check_val("rst_out_inst", bus.out_inst, 32'd0);
        check_val("rst_out_badmem", 32'(bus.out_badmem), 32'd0);
        sb.delete();
        resp_now = 1'b0;
        pend     = 1'b0;
        halted   = 1'b0;
        exp_addr = 32'h0000_0200;
        #1 reset = 1'b0;
        @(negedge clk);
        sample_phase();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_wait     = 1'b0;
        bus.out_ready     = 1'b0;
        bus.imem_rdata    = '0;
        bus.imem_badmem_e = 1'b0;

        // Free-running stream from reset
        ready_c = 1'b1;
        do_reset();
        repeat (12) cycle();

        // DX stalled: queue fills to DEPTH, then drains in order
        ready_c = 1'b0;
        do_reset();
        repeat (10) cycle();
        ready_c = 1'b1;
        repeat (8) cycle();

        // Memory busy mid-stream
        repeat (2) cycle();
        wait_c = 1'b1;
        repeat (3) cycle();
        wait_c = 1'b0;
        repeat (6) cycle();

        // Redirect with two queued entries and one response outstanding
        ready_c = 1'b0;
        do_reset();
        for (int g = 0; g < 20 && !(sb.size() == 2 && pend); g++) cycle();
        check_val("redir_setup", 32'(sb.size() == 2 && pend), 32'd1);
        redir_c = 1'b1;
        rpc_c   = 32'h0000_1003;
        cycle();
        redir_c = 1'b0;
        repeat (3) cycle();
        check_val("redir_valid_r3", 32'(bus.out_valid), 32'd1);
        check_val("redir_pc_r3", bus.out_pc, 32'h0000_1000);
        ready_c = 1'b1;
        repeat (6) cycle();

        // Fetch fault at 0x210 halts fetch until a redirect
        bad_addr = 32'h0000_0210;
        do_reset();
        repeat (20) cycle();
        check_val("bad_delivered", 32'(bad_seen), 32'd1);
        redir_c = 1'b1;
        rpc_c   = 32'h0000_0300;
        cycle();
        redir_c = 1'b0;
        repeat (8) cycle();
        bad_addr = 32'h0000_0001;

        // Address wrap, then asynchronous reset mid-stream
        redir_c = 1'b1;
        rpc_c   = 32'hFFFF_FFF8;
        cycle();
        redir_c = 1'b0;
        repeat (6) cycle();
        do_reset();
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
